// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite bus bundle shared by the register-file responder and its master.
// The master modport drives requests; the slave modport drives ready/response signals.
interface axi_lite_slave_regs_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register file with independent write and read FSMs, one outstanding access each.
// Optional macro AXIL_SLAVE_WSTRB_EN enables per-byte write strobes (default: full-word writes).
module axi_lite_slave_regs #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16
) (
   input  logic                 aclk_i,
   input  logic                 areset_n_i,
   axi_lite_slave_regs_if.slave bus
);
   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(NUM_REGS);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
   typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

   // Everything above the byte-offset and index fields must be zero to hit a register.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return (a >> (OFF_W + IDX_W)) == {ADDR_W{1'b0}};
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
      return a[OFF_W +: IDX_W];
   endfunction

   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] res;
      res = old_w;
      for (int i = 0; i < STRB_W; i++) begin
         if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

   w_state_e            w_state_q;
   logic                aw_got_q, w_got_q;
   logic [ADDR_W-1:0]   awaddr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [STRB_W-1:0]   wstrb_q;
   logic                awready_q, wready_q, bvalid_q;
   logic [1:0]          bresp_q;

   r_state_e            r_state_q;
   logic                arready_q, rvalid_q;
   logic [1:0]          rresp_q;
   logic [DATA_W-1:0]   rdata_q;

   logic [DATA_W-1:0]   regs_q [NUM_REGS];

   logic                aw_hs_s, w_hs_s, wr_fire_s, wr_en_s;
   logic [ADDR_W-1:0]   wr_addr_s;
   logic [DATA_W-1:0]   wr_data_s, wr_word_s;
   logic [STRB_W-1:0]   wr_strb_s;

   // Write commit: the later of AW/W uses the live bus payload, the earlier one its latched copy.
   always_comb begin
      aw_hs_s   = bus.awvalid && awready_q;
      w_hs_s    = bus.wvalid && wready_q;
      wr_addr_s = aw_hs_s ? bus.awaddr : awaddr_q;
      wr_data_s = w_hs_s ? bus.wdata : wdata_q;
      wr_strb_s = w_hs_s ? bus.wstrb : wstrb_q;
      wr_fire_s = (w_state_q == W_IDLE) && (aw_got_q || aw_hs_s) && (w_got_q || w_hs_s);
      wr_en_s   = wr_fire_s && addr_ok(wr_addr_s);
   end

`ifdef AXIL_SLAVE_WSTRB_EN
   assign wr_word_s = merge_bytes(regs_q[addr_idx(wr_addr_s)], wr_data_s, wr_strb_s);
`else
   logic unused_strb_s;
   assign unused_strb_s = ^{wr_strb_s, merge_bytes(wr_data_s, wr_data_s, wr_strb_s)};
   assign wr_word_s     = wr_data_s;
`endif

   // Register array update.
   always_ff @(posedge aclk_i or negedge areset_n_i) begin
      if (!areset_n_i) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= {DATA_W{1'b0}};
      end else if (wr_en_s) begin
         regs_q[addr_idx(wr_addr_s)] <= wr_word_s;
      end
   end

   // Write channel FSM: collect AW and W in any order, then hold B until accepted.
   always_ff @(posedge aclk_i or negedge areset_n_i) begin
      if (!areset_n_i) begin
         w_state_q <= W_IDLE;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         awaddr_q  <= {ADDR_W{1'b0}};
         wdata_q   <= {DATA_W{1'b0}};
         wstrb_q   <= {STRB_W{1'b0}};
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         case (w_state_q)
            W_IDLE: begin
               if (aw_hs_s) begin
                  aw_got_q <= 1'b1;
                  awaddr_q <= bus.awaddr;
               end
               if (w_hs_s) begin
                  w_got_q <= 1'b1;
                  wdata_q <= bus.wdata;
                  wstrb_q <= bus.wstrb;
               end
               if (wr_fire_s) begin
                  aw_got_q  <= 1'b0;
                  w_got_q   <= 1'b0;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= addr_ok(wr_addr_s) ? RESP_OKAY : RESP_SLVERR;
                  w_state_q <= W_RESP;
               end else begin
                  awready_q <= !(aw_got_q || aw_hs_s);
                  wready_q  <= !(w_got_q || w_hs_s);
               end
            end
            W_RESP: begin
               if (bus.bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  w_state_q <= W_IDLE;
               end
            end
            default: begin
               bvalid_q  <= 1'b0;
               w_state_q <= W_IDLE;
            end
         endcase
      end
   end

   // Read channel FSM: sample the array on the AR handshake, hold R until accepted.
   always_ff @(posedge aclk_i or negedge areset_n_i) begin
      if (!areset_n_i) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= {DATA_W{1'b0}};
      end else begin
         case (r_state_q)
            R_IDLE: begin
               if (bus.arvalid && arready_q) begin
                  rdata_q   <= addr_ok(bus.araddr) ? regs_q[addr_idx(bus.araddr)] : {DATA_W{1'b0}};
                  rresp_q   <= addr_ok(bus.araddr) ? RESP_OKAY : RESP_SLVERR;
                  rvalid_q  <= 1'b1;
                  arready_q <= 1'b0;
                  r_state_q <= R_DATA;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (bus.rready) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  r_state_q <= R_IDLE;
               end
            end
            default: begin
               rvalid_q  <= 1'b0;
               r_state_q <= R_IDLE;
            end
         endcase
      end
   end

   assign bus.awready = awready_q;
   assign bus.wready  = wready_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.bresp   = bresp_q;
   assign bus.arready = arready_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rresp   = rresp_q;
   assign bus.rdata   = rdata_q;
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Randomized scoreboard bench for axi_lite_slave_regs against a word-array reference model.
// Stimulus tasks push expected B/R responses; a negedge monitor pops and compares on handshakes.
module tb_axi_lite_slave_regs;
   logic aclk = 1'b0;
   logic areset_n;
   always #5 aclk = ~aclk;

   axi_lite_slave_regs_if #(.ADDR_W(12), .DATA_W(32)) bus ();

   axi_lite_slave_regs #(.ADDR_W(12), .DATA_W(32), .NUM_REGS(16)) dut (
      .aclk_i     (aclk),
      .areset_n_i (areset_n),
      .bus        (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] model [16];
   logic [1:0]  exp_b_q [$];
   logic [33:0] exp_r_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [1:0] model_write(input logic [11:0] addr, input logic [31:0] data,
                                              input logic [3:0] strb);
      if (addr >= 12'h040) return 2'b10;
`ifdef AXIL_SLAVE_WSTRB_EN
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) model[addr / 4][8*b +: 8] = data[8*b +: 8];
      end
`else
      if (strb == 4'hF || strb != 4'hF) model[addr / 4] = data;
`endif
      return 2'b00;
   endfunction

   function automatic logic [33:0] model_read(input logic [11:0] addr);
      if (addr >= 12'h040) return {2'b10, 32'h0};
      return {2'b00, model[addr / 4]};
   endfunction

   // Scoreboard monitor: a handshake seen at negedge completes on the next posedge.
   always @(negedge aclk) begin : monitor
      logic [1:0]  eb;
      logic [33:0] er;
      if (bus.bvalid && bus.bready) begin
         if (exp_b_q.size() == 0) begin
            n_checks++;
            $display("FAIL b_unexpected: got bresp %b with no expected response", bus.bresp);
         end else begin
            eb = exp_b_q.pop_front();
            check("bresp", 32'(bus.bresp), 32'(eb));
         end
      end
      if (bus.rvalid && bus.rready) begin
         if (exp_r_q.size() == 0) begin
            n_checks++;
            $display("FAIL r_unexpected: got rdata %h with no expected response", bus.rdata);
         end else begin
            er = exp_r_q.pop_front();
            check("rdata", bus.rdata, er[31:0]);
            check("rresp", 32'(bus.rresp), 32'(er[33:32]));
         end
      end
   end

   task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, input bit probe_aw);
      bit aw_done = 1'b0, w_done = 1'b0, aw_fire, w_fire;
      int t = 0;
      logic [1:0] eresp;
      bus.awaddr = addr;
      bus.wdata  = data;
      bus.wstrb  = strb;
      while (!(aw_done && w_done) && t < 50) begin
         bus.awvalid = !aw_done && (t >= aw_dly);
         bus.wvalid  = !w_done && (t >= w_dly);
         @(negedge aclk);
         aw_fire = bus.awvalid && bus.awready;
         w_fire  = bus.wvalid && bus.wready;
         @(posedge aclk); #1;
         if (aw_fire) aw_done = 1'b1;
         if (w_fire) w_done = 1'b1;
         t++;
      end
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      if (!(aw_done && w_done)) begin
         n_checks++;
         $display("FAIL write_timeout: addr %h aw_done %0d w_done %0d", addr, aw_done, w_done);
         return;
      end
      eresp = model_write(addr, data, strb);
      exp_b_q.push_back(eresp);
      check("bvalid_latency", 32'(bus.bvalid), 32'd1);
      check("readies_in_resp", 32'({bus.awready, bus.wready}), 32'd0);
      for (int i = 0; i < b_dly; i++) begin
         bus.awvalid = probe_aw;
         @(negedge aclk);
         check("bvalid_hold", 32'(bus.bvalid), 32'd1);
         check("bresp_hold", 32'(bus.bresp), 32'(eresp));
         check("awready_blocked", 32'(bus.awready), 32'd0);
         @(posedge aclk); #1;
      end
      bus.awvalid = 1'b0;
      bus.bready  = 1'b1;
      @(negedge aclk);
      @(posedge aclk); #1;
      bus.bready = 1'b0;
   endtask

   task automatic axi_read(input logic [11:0] addr, input int r_dly);
      bit fired = 1'b0;
      int t = 0;
      logic [33:0] e;
      bus.araddr = addr;
      while (!fired && t < 50) begin
         bus.arvalid = 1'b1;
         @(negedge aclk);
         fired = bus.arready;
         @(posedge aclk); #1;
         t++;
      end
      bus.arvalid = 1'b0;
      if (!fired) begin
         n_checks++;
         $display("FAIL read_timeout: addr %h", addr);
         return;
      end
      e = model_read(addr);
      exp_r_q.push_back(e);
      check("rvalid_latency", 32'(bus.rvalid), 32'd1);
      check("arready_in_rdata", 32'(bus.arready), 32'd0);
      for (int i = 0; i < r_dly; i++) begin
         @(negedge aclk);
         check("rvalid_hold", 32'(bus.rvalid), 32'd1);
         check("rdata_hold", bus.rdata, e[31:0]);
         @(posedge aclk); #1;
      end
      bus.rready = 1'b1;
      @(negedge aclk);
      @(posedge aclk); #1;
      bus.rready = 1'b0;
   endtask

   // AW, W and AR all handshake on one edge; the read must see the pre-write value.
   task automatic axi_wr_rd_same(input logic [11:0] addr, input logic [31:0] data);
      exp_r_q.push_back(model_read(addr));
      bus.awaddr  = addr;
      bus.wdata   = data;
      bus.wstrb   = 4'hF;
      bus.araddr  = addr;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      bus.arvalid = 1'b1;
      @(negedge aclk);
      check("same_edge_readies", 32'({bus.awready, bus.wready, bus.arready}), 32'd7);
      @(posedge aclk); #1;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      bus.arvalid = 1'b0;
      exp_b_q.push_back(model_write(addr, data, 4'hF));
      check("same_edge_valids", 32'({bus.bvalid, bus.rvalid}), 32'd3);
      bus.bready = 1'b1;
      bus.rready = 1'b1;
      @(negedge aclk);
      @(posedge aclk); #1;
      bus.bready = 1'b0;
      bus.rready = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int op;
      logic [11:0] a;
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
      bus.awaddr = 12'h0; bus.awvalid = 1'b0; bus.wdata = 32'h0; bus.wstrb = 4'h0;
      bus.wvalid = 1'b0;  bus.bready = 1'b0;  bus.araddr = 12'h0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;
      areset_n = 1'b1;
      #2 areset_n = 1'b0;
      #1;
      check("rst_readies", 32'({bus.awready, bus.wready, bus.arready}), 32'd0);
      check("rst_valids", 32'({bus.bvalid, bus.rvalid}), 32'd0);
      check("rst_resps", 32'({bus.bresp, bus.rresp}), 32'd0);
      check("rst_rdata", bus.rdata, 32'h0);
      repeat (3) @(negedge aclk);
      areset_n = 1'b1;
      @(posedge aclk); #1;
      check("ready_after_rst", 32'({bus.awready, bus.wready, bus.arready}), 32'd7);

      // Directed: same-cycle AW/W, then read back.
      axi_write(12'h004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b0);
      axi_read(12'h004, 0);
      // W leads AW by three cycles.
      axi_write(12'h008, 32'h12345678, 4'hF, 3, 0, 0, 1'b0);
      axi_read(12'h008, 1);
      // Out-of-range write and read.
      axi_write(12'h040, 32'hCAFEF00D, 4'hF, 0, 0, 0, 1'b0);
      axi_read(12'h040, 0);
      axi_read(12'h000, 0);
      // B stalled five cycles with a competing AW presented.
      axi_write(12'h010, 32'h0BADC0DE, 4'hF, 0, 1, 5, 1'b1);
      axi_read(12'h010, 0);
      // Same-edge write and read of a zero register.
      axi_wr_rd_same(12'h00C, 32'hA5A5A5A5);
      axi_read(12'h00C, 0);
      // Low offset bits are ignored.
      axi_read(12'h00B, 0);
`ifdef AXIL_SLAVE_WSTRB_EN
      axi_write(12'h014, 32'hFFFFFFFF, 4'b0011, 0, 0, 0, 1'b0);
      axi_read(12'h014, 0);
      axi_write(12'h014, 32'h12345678, 4'b0000, 0, 0, 0, 1'b0);
      axi_read(12'h014, 0);
`endif

      for (int n = 0; n < 40; n++) begin
         op = $urandom_range(0, 4);
         a  = 12'($urandom_range(0, 12'h04F));
         if (op <= 1)
            axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
         else if (op <= 3)
            axi_read(a, $urandom_range(0, 2));
         else
            axi_wr_rd_same(a, $urandom);
      end

      // Reset while a read response is pending drops it and clears the array.
      bus.araddr  = 12'h004;
      bus.arvalid = 1'b1;
      @(negedge aclk);
      @(posedge aclk); #1;
      bus.arvalid = 1'b0;
      check("rvalid_before_rst", 32'(bus.rvalid), 32'd1);
      #2 areset_n = 1'b0;
      #1;
      check("rvalid_async_rst", 32'(bus.rvalid), 32'd0);
      check("arready_async_rst", 32'(bus.arready), 32'd0);
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
      repeat (2) @(negedge aclk);
      areset_n = 1'b1;
      @(posedge aclk); #1;
      for (int i = 0; i < 16; i++) axi_read(12'(i * 4), 0);

      repeat (2) @(posedge aclk);
      check("b_queue_drained", 32'(exp_b_q.size()), 32'd0);
      check("r_queue_drained", 32'(exp_r_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
